// File: rtl/spart_bus_arbiter.sv
// spart_bus_arbiter
// Shares one SPART processor-side bus between two requesters. After reset,
// and again whenever br_cfg changes, it writes the baud divisor (low byte,
// then high byte). Otherwise it serialises TX-write and RX-read operations
// from the two requesters, using round-robin arbitration.
//
// Every output is registered. A state's bus activity therefore shows up
// in the cycle after that state is active. So the XFER bus cycle comes one
// cycle after the state register holds XFER. Read data is captured on the
// edge that closes that bus cycle, which is the DONE edge.

module spart_bus_arbiter #(
  parameter logic [15:0] DIV0 = 16'd650,
  parameter logic [15:0] DIV1 = 16'd325,
  parameter logic [15:0] DIV2 = 16'd162,
  parameter logic [15:0] DIV3 = 16'd80
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_cfg,
  output logic       cfg_done,
  input  logic       req0_valid,
  input  logic       req0_write,
  input  logic [7:0] req0_wdata,
  output logic       req0_ready,
  output logic [7:0] req0_rdata,
  input  logic       req1_valid,
  input  logic       req1_write,
  input  logic [7:0] req1_wdata,
  output logic       req1_ready,
  output logic [7:0] req1_rdata,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  input  logic       rda,
  input  logic       tbr
);

  typedef enum logic [2:0] {
    CFG_LO,
    CFG_HI,
    IDLE,
    WAIT,
    XFER,
    DONE
  } state_t;

  state_t      state;
  logic [1:0]  cfg_reg;
  logic [7:0]  dout;
  logic        rr_ptr;
  logic        grant;
  logic        op_write;
  logic [7:0]  op_wdata;
  logic        pick;
  logic        other_valid;
  logic [15:0] div_new;
  logic [15:0] div_cur;

  function automatic logic [15:0] divisor(input logic [1:0] sel);
    case (sel)
      2'b00:   divisor = DIV0;
      2'b01:   divisor = DIV1;
      2'b10:   divisor = DIV2;
      default: divisor = DIV3;
    endcase
  endfunction

  // The arbiter drives the bus only for its own writes. During reads the SPART owns the bus.
  assign databus = (iocs && !iorw) ? dout : 8'hzz;

  // Divisor lookups: one for the value being latched now, one for the value already latched.
  always_comb begin
    div_new = divisor(br_cfg);
    div_cur = divisor(cfg_reg);
  end

  // Round-robin pick among pending requesters, and the pending state of the requester not granted.
  always_comb begin
    pick = 1'b0;
    if (req0_valid && req1_valid)
      pick = rr_ptr;
    else if (req1_valid)
      pick = 1'b1;
    other_valid = grant ? req0_valid : req1_valid;
  end

  // Main sequencer: divisor programming, arbitration, the bus transfer and the completion pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CFG_LO;
      cfg_reg    <= 2'b00;
      cfg_done   <= 1'b0;
      iocs       <= 1'b0;
      iorw       <= 1'b1;
      ioaddr     <= 2'b00;
      dout       <= 8'h00;
      rr_ptr     <= 1'b0;
      grant      <= 1'b0;
      op_write   <= 1'b0;
      op_wdata   <= 8'h00;
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      req0_rdata <= 8'h00;
      req1_rdata <= 8'h00;
    end else begin
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      iocs       <= 1'b0;
      iorw       <= 1'b1;
      ioaddr     <= 2'b00;
      case (state)
        CFG_LO: begin
          cfg_reg <= br_cfg;
          iocs    <= 1'b1;
          iorw    <= 1'b0;
          ioaddr  <= 2'b10;
          dout    <= div_new[7:0];
          state   <= CFG_HI;
        end
        CFG_HI: begin
          iocs     <= 1'b1;
          iorw     <= 1'b0;
          ioaddr   <= 2'b11;
          dout     <= div_cur[15:8];
          cfg_done <= 1'b1;
          state    <= IDLE;
        end
        IDLE: begin
          if (br_cfg != cfg_reg) begin
            cfg_done <= 1'b0;
            state    <= CFG_LO;
          end else if (req0_valid || req1_valid) begin
            grant    <= pick;
            op_write <= pick ? req1_write : req0_write;
            op_wdata <= pick ? req1_wdata : req0_wdata;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (op_write) begin
            if (tbr)
              state <= XFER;
          end else if (rda) begin
            state <= XFER;
          end else if (other_valid) begin
            rr_ptr <= ~grant;
            state  <= IDLE;
          end
        end
        XFER: begin
          iocs   <= 1'b1;
          iorw   <= ~op_write;
          ioaddr <= 2'b00;
          dout   <= op_wdata;
          state  <= DONE;
        end
        DONE: begin
          if (grant) begin
            req1_ready <= 1'b1;
            if (!op_write)
              req1_rdata <= databus;
          end else begin
            req0_ready <= 1'b1;
            if (!op_write)
              req0_rdata <= databus;
          end
          rr_ptr <= ~grant;
          state  <= IDLE;
        end
        default: state <= CFG_LO;
      endcase
    end
  end

endmodule

// File: tb/tb_spart_bus_arbiter.sv
// tb_spart_bus_arbiter
// Directed testbench for spart_bus_arbiter. It uses hand-computed expectations.
// A simple SPART stand-in drives rx_byte onto the bus during read cycles.

module tb_spart_bus_arbiter;

  logic       clk;
  logic       rst;
  logic [1:0] br_cfg;
  logic       cfg_done;
  logic       req0_valid, req0_write, req0_ready;
  logic [7:0] req0_wdata, req0_rdata;
  logic       req1_valid, req1_write, req1_ready;
  logic [7:0] req1_wdata, req1_rdata;
  logic       iocs, iorw;
  logic [1:0] ioaddr;
  wire  [7:0] databus;
  logic       rda, tbr;
  logic [7:0] rx_byte;

  int checks = 0;
  int errors = 0;

  spart_bus_arbiter dut (
    .clk(clk), .rst(rst), .br_cfg(br_cfg), .cfg_done(cfg_done),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_wdata(req0_wdata),
    .req0_ready(req0_ready), .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_wdata(req1_wdata),
    .req1_ready(req1_ready), .req1_rdata(req1_rdata),
    .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr), .databus(databus),
    .rda(rda), .tbr(tbr)
  );

  // SPART stand-in: puts the receive byte on the bus whenever the arbiter reads.
  assign databus = (iocs && iorw) ? rx_byte : 8'hzz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends on its own.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, required finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic w0, input logic [7:0] d0,
                               input logic v1, input logic w1, input logic [7:0] d1);
    req0_valid = v0; req0_write = w0; req0_wdata = d0;
    req1_valid = v1; req1_write = w1; req1_wdata = d1;
  endtask

  task automatic stepClock;
    @(posedge clk);
    #1;
  endtask

  // Steps until the chosen requester's ready pulses, or until the budget runs out.
  task automatic waitReady(input int which, input int max_cycles, output int cycles,
                           output logic [7:0] wbyte, output logic other_seen);
    logic found;
    found = 1'b0;
    cycles = 0;
    wbyte = 8'h00;
    other_seen = 1'b0;
    while (!found && cycles < max_cycles) begin
      stepClock();
      cycles++;
      if (iocs && !iorw && ioaddr == 2'b00) wbyte = databus;
      if (which == 0) begin
        if (req1_ready) other_seen = 1'b1;
        if (req0_ready) found = 1'b1;
      end else begin
        if (req0_ready) other_seen = 1'b1;
        if (req1_ready) found = 1'b1;
      end
    end
    checkOutput("ready_seen", {31'd0, found}, 32'd1);
  endtask

  initial begin
    int n;
    logic [7:0] wb;
    logic other;
    logic bus_active;
    int expect_who;

    rst = 1'b1; br_cfg = 2'b00; rda = 1'b0; tbr = 1'b0; rx_byte = 8'h00;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);

    // Reset state.
    stepClock();
    checkOutput("rst_iocs", {31'd0, iocs}, 32'd0);
    checkOutput("rst_iorw", {31'd0, iorw}, 32'd1);
    checkOutput("rst_ioaddr", {30'd0, ioaddr}, 32'd0);
    checkOutput("rst_cfg_done", {31'd0, cfg_done}, 32'd0);
    checkOutput("rst_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
    checkOutput("rst_rdata", {16'd0, req0_rdata, req1_rdata}, 32'd0);
    rst = 1'b0;

    // Divisor programming for br_cfg=00 (650 = 0x028A).
    stepClock();
    checkOutput("cfg_lo_ctl", {28'd0, iocs, iorw, ioaddr}, {28'd0, 1'b1, 1'b0, 2'b10});
    checkOutput("cfg_lo_data", {24'd0, databus}, 32'h8A);
    stepClock();
    checkOutput("cfg_hi_ctl", {28'd0, iocs, iorw, ioaddr}, {28'd0, 1'b1, 1'b0, 2'b11});
    checkOutput("cfg_hi_data", {24'd0, databus}, 32'h02);
    stepClock();
    checkOutput("cfg_done_up", {31'd0, cfg_done}, 32'd1);
    checkOutput("cfg_bus_idle", {31'd0, iocs}, 32'd0);

    // req0 write 0x48 with tbr high. Grant, WAIT, bus cycle, then the ready pulse.
    tbr = 1'b1;
    applyStimulus(1'b1, 1'b1, 8'h48, 1'b0, 1'b0, 8'h00);
    stepClock();
    stepClock();
    checkOutput("wr_no_bus_yet", {31'd0, iocs}, 32'd0);
    stepClock();
    checkOutput("wr_xfer_ctl", {28'd0, iocs, iorw, ioaddr}, {28'd0, 1'b1, 1'b0, 2'b00});
    checkOutput("wr_xfer_data", {24'd0, databus}, 32'h48);
    checkOutput("wr_ready_early", {31'd0, req0_ready}, 32'd0);
    stepClock();
    checkOutput("wr_ready", {30'd0, req0_ready, req1_ready}, 32'b10);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    stepClock();
    checkOutput("wr_ready_pulse", {31'd0, req0_ready}, 32'd0);

    // req1 read. rda stays low for 20 cycles and the bus must stay idle throughout.
    tbr = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    bus_active = 1'b0;
    for (int i = 0; i < 20; i++) begin
      stepClock();
      if (iocs || req1_ready) bus_active = 1'b1;
    end
    checkOutput("rd_wait_idle", {31'd0, bus_active}, 32'd0);
    rda = 1'b1; rx_byte = 8'h4C;
    waitReady(1, 10, n, wb, other);
    checkOutput("rd_latency", n, 32'd3);
    checkOutput("rd_rdata", {24'd0, req1_rdata}, 32'h4C);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    rda = 1'b0; rx_byte = 8'h00;
    stepClock();
    checkOutput("rd_ready_pulse", {31'd0, req1_ready}, 32'd0);
    checkOutput("rd_rdata_held", {24'd0, req1_rdata}, 32'h4C);
    checkOutput("rd_other_rdata", {24'd0, req0_rdata}, 32'h00);

    // Both requesters keep valid asserted with writes. Grants must alternate 0,1,0,1.
    tbr = 1'b1;
    applyStimulus(1'b1, 1'b1, 8'hA0, 1'b1, 1'b1, 8'hB1);
    expect_who = 0;
    for (int k = 0; k < 4; k++) begin
      waitReady(expect_who, 10, n, wb, other);
      checkOutput("rr_other_ready", {31'd0, other}, 32'd0);
      checkOutput("rr_wbyte", {24'd0, wb}, (expect_who == 0) ? 32'hA0 : 32'hB1);
      if (k > 0) checkOutput("rr_spacing", n, 32'd4);
      expect_who = 1 - expect_who;
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    stepClock();
    checkOutput("rr_pulse_end", {30'd0, req0_ready, req1_ready}, 32'd0);
    stepClock();

    // req0 read is pending with rda low. A req1 write arrives, so req0 yields and 0x21 is written first.
    tbr = 1'b1;
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    stepClock();
    stepClock();
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h21);
    waitReady(1, 12, n, wb, other);
    checkOutput("yield_latency", n, 32'd5);
    checkOutput("yield_wbyte", {24'd0, wb}, 32'h21);
    checkOutput("yield_no_req0_ready", {31'd0, other}, 32'd0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) stepClock();
    checkOutput("yield_req0_waiting", {31'd0, req0_ready}, 32'd0);
    rda = 1'b1; rx_byte = 8'h5A;
    waitReady(0, 10, n, wb, other);
    checkOutput("regrant_latency", n, 32'd3);
    checkOutput("regrant_rdata", {24'd0, req0_rdata}, 32'h5A);
    checkOutput("regrant_req1_rdata", {24'd0, req1_rdata}, 32'h4C);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    rda = 1'b0; rx_byte = 8'h00;
    stepClock();
    stepClock();

    // br_cfg 00 -> 11 while idle. The divisor 80 = 0x0050 is written again and cfg_done drops for two cycles.
    br_cfg = 2'b11;
    stepClock();
    checkOutput("recfg_done_low1", {31'd0, cfg_done}, 32'd0);
    checkOutput("recfg_idle", {31'd0, iocs}, 32'd0);
    stepClock();
    checkOutput("recfg_done_low2", {31'd0, cfg_done}, 32'd0);
    checkOutput("recfg_lo", {20'd0, iocs, iorw, ioaddr, databus}, {20'd0, 1'b1, 1'b0, 2'b10, 8'h50});
    stepClock();
    checkOutput("recfg_hi", {20'd0, iocs, iorw, ioaddr, databus}, {20'd0, 1'b1, 1'b0, 2'b11, 8'h00});
    checkOutput("recfg_done_back", {31'd0, cfg_done}, 32'd1);
    stepClock();
    checkOutput("recfg_bus_idle", {31'd0, iocs}, 32'd0);

    // Reset during WAIT (write held off by tbr=0). Expect no ready, the bus released, and CFG_LO next.
    tbr = 1'b0;
    applyStimulus(1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 8'h00);
    stepClock();
    stepClock();
    rst = 1'b1;
    tbr = 1'b1;
    stepClock();
    checkOutput("abort_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
    checkOutput("abort_bus_released", {31'd0, (iocs && !iorw)}, 32'd0);
    checkOutput("abort_cfg_done", {31'd0, cfg_done}, 32'd0);
    checkOutput("abort_rdata", {24'd0, req1_rdata}, 32'h00);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    stepClock();
    checkOutput("abort_cfg_lo", {20'd0, iocs, iorw, ioaddr, databus}, {20'd0, 1'b1, 1'b0, 2'b10, 8'h50});
    checkOutput("abort_no_ready", {30'd0, req0_ready, req1_ready}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spart_bus_arbiter.md
Name: spart_bus_arbiter

Overview:
- Sits between two requesters (the echo driver and a message/status source) and one SPART's processor-side bus (iocs/iorw/ioaddr/databus, rda/tbr).
- After reset, programs the SPART baud divisor from br_cfg.
- Then serialises TX-write and RX-read requests from both requesters onto the single bus with round-robin arbitration.
- Reprograms the divisor whenever br_cfg changes.

Parameters:
- DIV0, 16'd650, divisor for br_cfg=00 (4800 baud @ 50 MHz)
- DIV1, 16'd325, divisor for br_cfg=01 (9600)
- DIV2, 16'd162, divisor for br_cfg=10 (19200)
- DIV3, 16'd80, divisor for br_cfg=11 (38400)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- br_cfg  in  2  baud select
- cfg_done  out  1  high once the divisor matching the current br_cfg is written
- req0_valid  in  1  requester 0 has an operation pending; held until req0_ready
- req0_write  in  1  1 = TX write, 0 = RX read; stable while valid
- req0_wdata  in  8  TX byte; stable while valid
- req0_ready  out  1  one-cycle completion pulse
- req0_rdata  out  8  RX byte; valid when req0_ready=1, held until next read completion
- req1_valid, req1_write, req1_wdata, req1_ready, req1_rdata: same as requester 0
- iocs  out  1  SPART chip select
- iorw  out  1  1 = read, 0 = write
- ioaddr  out  2  00 = TX/RX buffer, 01 = status, 10 = DB low, 11 = DB high
- databus  inout  8  driven only when iocs=1 and iorw=0, else Z
- rda  in  1  SPART receive data available
- tbr  in  1  SPART transmit buffer ready

Behaviour:
- Reset values: iocs=0, iorw=1, ioaddr=00, databus=Z, cfg_done=0, reqN_ready=0, reqN_rdata=8'h00, round-robin pointer favours requester 0. State goes to CFG_LO.
- Reset asserted mid-operation aborts everything in the next cycle: no ready pulse, bus released, state back to CFG_LO.
- States: CFG_LO, CFG_HI, IDLE, WAIT, XFER, DONE.
- CFG_LO:
  - Samples br_cfg into cfg_reg.
  - Drives iocs=1, iorw=0, ioaddr=10, databus=DIV[7:0].
  - Next state: CFG_HI.
- CFG_HI:
  - Drives ioaddr=11, databus=DIV[15:8].
  - Next state: IDLE; cfg_done=1 from the next cycle.
- IDLE (bus idle):
  - If br_cfg != cfg_reg: cfg_done goes 0, next state CFG_LO. This has priority over pending requests, which stay pending.
  - Else, if any reqN_valid: grant per round-robin. The pointer favours the requester not served last.
  - Latch the grant, op and wdata; next state WAIT.
- WAIT (bus idle):
  - Write: when tbr=1, go to XFER.
  - Read: when rda=1, go to XFER.
  - Read yield: if rda=0 and the other requester's valid=1, return to IDLE without completing. The pointer moves to the other requester. Writes never yield.
- XFER (exactly one cycle, iocs=1, ioaddr=00):
  - Write: iorw=0, databus=wdata.
  - Read: iorw=1, databus=Z; databus is captured into grantee's rdata at the clock edge ending XFER.
  - Next state: DONE.
- DONE:
  - Grantee's ready=1 for exactly one cycle; the pointer now favours the other requester.
  - Next state: IDLE.
  - Requester valid is sampled again only in IDLE, so it must drop the cycle after ready or a new op is issued.
- Minimum latency (valid seen in IDLE, condition already true): ready 3 cycles later. Bus throughput: one transfer per 4 cycles.
- Only one requester is granted at a time. The non-granted requester's ready stays 0 and its rdata is unchanged.
- Divisor select: 00→DIV0, 01→DIV1, 10→DIV2, 11→DIV3, 16-bit, low byte first.

Test Plan:
- Reset, br_cfg=00:
  - Cycle 1 after reset: iocs=1, iorw=0, ioaddr=10, databus=8'h8A.
  - Cycle 2: ioaddr=11, databus=8'h02.
  - Then cfg_done=1 and iocs=0.
- req0 write 8'h48 with tbr=1: XFER 2 cycles after grant with ioaddr=00, iorw=0, databus=8'h48; req0_ready pulses once 3 cycles after valid sampled.
- req1 read with rda low for 20 cycles, then rda=1 and databus=8'h4C: no bus activity while waiting; read XFER; req1_rdata=8'h4C with req1_ready pulse.
- Both valid continuously, each doing writes with tbr=1: grants alternate 0,1,0,1; each ready is a single-cycle pulse.
- req0 read pending (rda=0), req1 write 8'h21 asserted: req0 yields; 8'h21 written; req0 re-granted and completes when rda=1.
- br_cfg 00→11 while idle: CFG sequence writes 8'h50 then 8'h00; cfg_done low for the 2 cycles. Assert rst during WAIT: no ready, databus Z, CFG_LO next.
